// File: rtl/serial_uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// bit-timing helpers used by the serial transmitter (and later the receiver).
package serial_uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_MARK
  } uart_state_t;

  // Whole clocks per bit; the remainder is dropped.
  function automatic int ticks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // The truncated bit period makes each bit slightly short. Over a frame the
  // accumulated drift must stay below half a bit for the far end to sample it.
  function automatic logic frame_timing_ok(input int clk_hz, input int baud,
                                           input int frame_bits);
    longint tpb;
    longint err;
    tpb = longint'(clk_hz / baud);
    err = longint'(clk_hz) - tpb * longint'(baud);
    return (longint'(2 * frame_bits) * err) < (tpb * longint'(baud));
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Free-running bit timer: counts 0..TICKS-1 and raises done_o during the last
// clock of every bit. The strobe is registered one count early so it needs no
// decode after the flop and each bit lasts exactly TICKS clocks.
module serial_bit_timer #(
  parameter int TICKS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic done_o
);

  localparam int            CW   = (TICKS > 2) ? $clog2(TICKS) : 2;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICKS - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Next count and early done strobe; clear holds the timer at the bit start.
  always_comb begin
    cnt_d  = '0;
    done_d = 1'b0;
    if (!clear_i) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      done_d = (cnt_q == PRE);
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/serial_transmitter_cfg.sv
// Configurable UART transmitter: 5..9 data bits LSB first, optional odd/even
// parity, 1 or 2 stop bits and a level-driven break. A new payload may be
// handed over during the stop bits so frames follow without an idle gap.
module serial_transmitter_cfg
  import serial_uart_pkg::*;
#(
  parameter int pClockFrequency = 16000000,
  parameter int pBaudRate       = 115200,
  parameter int pDataBits       = 8,
  parameter int pParity         = 0,
  parameter int pStopBits       = 1
) (
  input  logic                 iClock,
  input  logic                 inReset,
  input  logic [pDataBits-1:0] iData,
  input  logic                 iSend,
  input  logic                 iBreak,
  output logic                 oReady,
  output logic                 oTxd
);

  localparam int TICKS      = ticks_per_bit(pClockFrequency, pBaudRate);
  localparam int FRAME_BITS = 1 + pDataBits + ((pParity != PAR_NONE) ? 1 : 0) + pStopBits;
  localparam int FRAME_CLKS = FRAME_BITS * TICKS;
  localparam int BW         = $clog2(FRAME_CLKS);
  localparam int IW         = $clog2(pDataBits);

  localparam logic [BW-1:0] BRK_MIN   = BW'(FRAME_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(pDataBits - 1);
  localparam logic          STOP_LAST = 1'(pStopBits - 1);

  if (TICKS < 3 || pDataBits < 5 || pDataBits > 9 || pParity > 2 ||
      (pStopBits != 1 && pStopBits != 2)) begin : g_bad_cfg
    $fatal(1, "serial_transmitter_cfg: illegal parameters clk=%0d baud=%0d bits=%0d par=%0d stop=%0d",
           pClockFrequency, pBaudRate, pDataBits, pParity, pStopBits);
  end

  if (!frame_timing_ok(pClockFrequency, pBaudRate, FRAME_BITS)) begin : g_drift
    $warning("serial_transmitter_cfg: bit period truncation drifts more than half a bit per frame");
  end

  uart_state_t          state_q, state_d;
  logic [pDataBits-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 pend_q, pend_d;
  logic [BW-1:0]        brk_q, brk_d;
  logic                 ready_q, ready_d;
  logic                 txd_q, txd_d;

  logic bit_done;
  logic tmr_clr;
  logic accept;
  logic par_calc;

  // Bit timing restarts at the first bit after IDLE and after a break.
  assign tmr_clr = (state_q == ST_IDLE) || (state_q == ST_BREAK);

  serial_bit_timer #(
    .TICKS (TICKS)
  ) u_timer (
    .clk_i   (iClock),
    .rst_ni  (inReset),
    .clear_i (tmr_clr),
    .done_o  (bit_done)
  );

  assign accept   = iSend && ready_q;
  assign par_calc = (pParity == PAR_ODD) ? ~(^iData) : (^iData);

  // Frame sequencing, payload shifter, handshake and break timing.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    pend_d  = pend_q;
    brk_d   = '0;
    ready_d = ready_q;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          shreg_d = iData;
          par_d   = par_calc;
          ready_d = 1'b0;
          state_d = ST_START;
        end else if (iBreak) begin
          ready_d = 1'b0;
          state_d = ST_BREAK;
        end
      end
      ST_START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) begin
            if (pParity != PAR_NONE) begin
              state_d = ST_PARITY;
            end else begin
              stop_d  = 1'b0;
              ready_d = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          stop_d  = 1'b0;
          ready_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Early hand-over: hold the next payload until the stop bits end.
        if (accept) begin
          shreg_d = iData;
          par_d   = par_calc;
          pend_d  = 1'b1;
          ready_d = 1'b0;
        end
        if (bit_done) begin
          if (stop_q == STOP_LAST) begin
            if (pend_q || accept) begin
              pend_d  = 1'b0;
              state_d = ST_START;
            end else if (iBreak) begin
              ready_d = 1'b0;
              state_d = ST_BREAK;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Saturating clock count enforces a break of at least one frame.
        brk_d = (brk_q == BRK_MIN) ? brk_q : brk_q + BW'(1);
        if (!iBreak && brk_q == BRK_MIN) begin
          stop_d  = 1'b0;
          state_d = ST_MARK;
        end
      end
      ST_MARK: begin
        if (bit_done) begin
          if (stop_q == STOP_LAST) state_d = ST_IDLE;
          else                     stop_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the current state; registered below so the pin never glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START, ST_BREAK: txd_d = 1'b0;
      ST_DATA:            txd_d = shreg_q[0];
      ST_PARITY:          txd_d = par_q;
      default:            txd_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and parks the line at mark.
  always_ff @(posedge iClock or negedge inReset) begin
    if (!inReset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      pend_q  <= 1'b0;
      brk_q   <= '0;
      ready_q <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      pend_q  <= pend_d;
      brk_q   <= brk_d;
      ready_q <= ready_d;
      txd_q   <= txd_d;
    end
  end

  assign oReady = ready_q;
  assign oTxd   = txd_q;

endmodule

// File: tb/tb_serial_transmitter_cfg.sv
// Bench for serial_transmitter_cfg: four configurations (8N1, 7E2, 7O2, 9N1)
// at 10 clocks per bit, checked clock-by-clock against frames built from the
// UART framing rules, plus break, back-to-back and reset scenarios.
module tb_serial_transmitter_cfg;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int T      = 10;
  localparam int NDUT   = 4;
  localparam int DB[NDUT] = '{8, 7, 7, 9};
  localparam int PR[NDUT] = '{0, 2, 1, 0};
  localparam int SB[NDUT] = '{1, 2, 2, 1};

  logic       clk;
  logic       rst_n;
  logic       send [NDUT];
  logic       brk  [NDUT];
  logic [8:0] data [NDUT];
  logic       txd  [NDUT];
  logic       rdy  [NDUT];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_transmitter_cfg #(.pClockFrequency(CLK_HZ), .pBaudRate(BAUD), .pDataBits(8),
                           .pParity(0), .pStopBits(1)) u_dut0 (
    .iClock(clk), .inReset(rst_n), .iData(data[0][7:0]), .iSend(send[0]),
    .iBreak(brk[0]), .oReady(rdy[0]), .oTxd(txd[0]));
  serial_transmitter_cfg #(.pClockFrequency(CLK_HZ), .pBaudRate(BAUD), .pDataBits(7),
                           .pParity(2), .pStopBits(2)) u_dut1 (
    .iClock(clk), .inReset(rst_n), .iData(data[1][6:0]), .iSend(send[1]),
    .iBreak(brk[1]), .oReady(rdy[1]), .oTxd(txd[1]));
  serial_transmitter_cfg #(.pClockFrequency(CLK_HZ), .pBaudRate(BAUD), .pDataBits(7),
                           .pParity(1), .pStopBits(2)) u_dut2 (
    .iClock(clk), .inReset(rst_n), .iData(data[2][6:0]), .iSend(send[2]),
    .iBreak(brk[2]), .oReady(rdy[2]), .oTxd(txd[2]));
  serial_transmitter_cfg #(.pClockFrequency(CLK_HZ), .pBaudRate(BAUD), .pDataBits(9),
                           .pParity(0), .pStopBits(1)) u_dut3 (
    .iClock(clk), .inReset(rst_n), .iData(data[3]), .iSend(send[3]),
    .iBreak(brk[3]), .oReady(rdy[3]), .oTxd(txd[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int k);
    return 1 + DB[k] + ((PR[k] != 0) ? 1 : 0) + SB[k];
  endfunction

  // Line bits of one frame, index 0 = start bit; unused positions stay high.
  function automatic logic [15:0] build_frame(input int k, input logic [8:0] v);
    logic [15:0] f;
    int n;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB[k]; i++) begin
      f[1 + i] = v[i];
      if (v[i]) ones++;
    end
    n = 1 + DB[k];
    if (PR[k] == 1) f[n] = ((ones % 2) == 0);
    if (PR[k] == 2) f[n] = ((ones % 2) == 1);
    return f;
  endfunction

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk($sformatf("ready_wait d%0d", k), 32'(rdy[k]), 32'd1);
  endtask

  // Returns just after the accepting edge.
  task automatic start_frame(input int k, input logic [8:0] v);
    wait_ready(k);
    data[k] = v;
    send[k] = 1'b1;
    tick();
    send[k] = 1'b0;
  endtask

  // Checks every clock of one frame; optionally hands over the next payload
  // during the first stop bit and/or raises iBreak mid-frame.
  task automatic check_frame(input int k, input logic [8:0] v, input bit nxt_en,
                             input logic [8:0] nxt_v, input bit brk_mid);
    logic [15:0]  f;
    logic [T-1:0] s;
    int n;
    int fs;
    f  = build_frame(k, v);
    n  = frame_len(k);
    fs = n - SB[k];
    for (int b = 0; b < n; b++) begin
      for (int t = 0; t < T; t++) begin
        tick();
        s[t] = txd[k];
        if (b == 0 && t == T / 2) chk($sformatf("ready_busy d%0d", k), 32'(rdy[k]), 32'd0);
        if (b == fs && t == 0) begin
          chk($sformatf("ready_stop d%0d", k), 32'(rdy[k]), 32'd1);
          if (nxt_en) begin
            data[k] = nxt_v;
            send[k] = 1'b1;
          end
        end
        if (b == fs && t == 1) send[k] = 1'b0;
        if (b == 2 && t == 3 && brk_mid) brk[k] = 1'b1;
      end
      chk($sformatf("d%0d v%03h bit%0d", k, v, b), 32'(s), 32'({T{f[b]}}));
    end
  endtask

  // Called just after the edge that entered the break with iBreak high.
  task automatic measure_break(input int k, input int hold, input int exp_low);
    int  lowc;
    int  markc;
    int  phase;
    bit  done;
    bit  rdy_bad;
    bit  mark_bad;
    lowc = 0; markc = 0; phase = 0; done = 0; rdy_bad = 0; mark_bad = 0;
    for (int c = 1; c <= 1500 && !done; c++) begin
      if (c == hold) brk[k] = 1'b0;
      tick();
      if (phase == 0 && txd[k] !== 1'b0) phase = 1;
      if (phase == 0) lowc++;
      if (phase == 1) begin
        if (rdy[k] === 1'b1) done = 1;
        else begin
          markc++;
          if (txd[k] !== 1'b1) mark_bad = 1;
        end
      end
      if (!done && rdy[k] !== 1'b0) rdy_bad = 1;
    end
    brk[k] = 1'b0;
    chk($sformatf("break_low d%0d", k), 32'(lowc), 32'(exp_low));
    chk($sformatf("break_mark_min d%0d", k), 32'(markc >= SB[k] * T), 32'd1);
    chk($sformatf("break_mark_line d%0d", k), 32'(mark_bad), 32'd0);
    chk($sformatf("break_ready_low d%0d", k), 32'(rdy_bad), 32'd0);
    chk($sformatf("break_end d%0d", k), 32'(done), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [8:0]  a;
    logic [8:0]  b;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      send[i] = 1'b0;
      brk[i]  = 1'b0;
      data[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset_txd d%0d", i), 32'(txd[i]), 32'd1);
      chk($sformatf("reset_ready d%0d", i), 32'(rdy[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("ready_after_reset d%0d", i), 32'(rdy[i]), 32'd1);

    // Directed frames.
    start_frame(0, 9'h0A5); check_frame(0, 9'h0A5, 0, 9'h0, 0);
    start_frame(1, 9'h041); check_frame(1, 9'h041, 0, 9'h0, 0);
    start_frame(2, 9'h041); check_frame(2, 9'h041, 0, 9'h0, 0);
    start_frame(3, 9'h1FF); check_frame(3, 9'h1FF, 0, 9'h0, 0);

    // Back-to-back hand-over during the stop bit.
    start_frame(0, 9'h0A5);
    check_frame(0, 9'h0A5, 1, 9'h055, 0);
    check_frame(0, 9'h055, 0, 9'h0, 0);

    // Break from idle, longer than a frame.
    wait_ready(0);
    brk[0] = 1'b1;
    tick();
    measure_break(0, 200, 200);

    // Short break request is stretched to one frame (7E2: 11 bits).
    wait_ready(1);
    brk[1] = 1'b1;
    tick();
    measure_break(1, 20, 11 * T);

    // Break raised mid-frame waits for the frame to finish.
    start_frame(0, 9'h0C3);
    check_frame(0, 9'h0C3, 0, 9'h0, 1);
    measure_break(0, 30, 10 * T);

    // Asynchronous reset during data bit 3.
    start_frame(0, 9'h0A5);
    repeat (4 * T + 5) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_txd", 32'(txd[0]), 32'd1);
    chk("async_reset_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("reset_release_ready", 32'(rdy[0]), 32'd0);
    chk("reset_release_txd", 32'(txd[0]), 32'd1);
    tick();
    chk("ready_one_clk_after_release", 32'(rdy[0]), 32'd1);
    start_frame(0, 9'h03C); check_frame(0, 9'h03C, 0, 9'h0, 0);

    // Randomized traffic across all configurations.
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, NDUT - 1);
      a = 9'($urandom) & 9'((1 << DB[k]) - 1);
      b = 9'($urandom) & 9'((1 << DB[k]) - 1);
      repeat ($urandom_range(0, 5)) tick();
      start_frame(k, a);
      if ($urandom_range(0, 1) == 1) begin
        check_frame(k, a, 1, b, 0);
        check_frame(k, b, 0, 9'h0, 0);
      end else begin
        check_frame(k, a, 0, 9'h0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
